// File: rtl/register_file_pkg.sv
// Shared definitions for the register file block.
// Contents: address width, entry count and the clear-sweep FSM state type.
package regfile_pkg;

   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

endpackage

// File: rtl/register_file_if.sv
// Bus bundle for the register file: one write port, two read ports and
// the clear-sweep handshake.
// master: drives write/read requests and clr_req, observes data and status.
// slave : the register file itself.
interface register_file_if #(parameter int DATA_W = 32);
   import regfile_pkg::*;

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [DATA_W-1:0] rd_data_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [DATA_W-1:0] rd_data_b;
   logic              clr_req;
   logic              busy;
   logic              clr_done;
   logic              wr_drop;

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, clr_req,
      input  rd_data_a, rd_data_b, busy, clr_done, wr_drop
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, clr_req,
      output rd_data_a, rd_data_b, busy, clr_done, wr_drop
   );

endinterface

// File: rtl/register_file_wr_decoder.sv
// Write-address decoder: turns a 5-bit entry index plus enable into a
// one-hot per-entry write enable (enable shifted left by the index).
// Ports: en (write enable), addr (entry index), onehot (per-entry enable).
module wr_decoder
   import regfile_pkg::*;
(
   input  logic                en,
   input  logic [ADDR_W-1:0]   addr,
   output logic [NUM_REGS-1:0] onehot
);

   assign onehot = {{(NUM_REGS-1){1'b0}}, en} << addr;

endmodule

// File: rtl/register_file.sv
// 32-entry register file, one write port, two combinational read ports,
// with a sequential clear sweep that zeroes entries 1..31 one per cycle.
// Entry 0 is hard-wired to zero.
// Ports: clk, rst_n (async active-low), bus (register_file_if.slave).
// Build option: define REGFILE_BYPASS_EN to forward an accepted write's
// data to a read port addressing the same entry in the same cycle.
//
// state | meaning
// IDLE  | normal operation, writes accepted
// SWEEP | clearing entry ptr each cycle, writes dropped, busy high
module register_file
   import regfile_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input logic             clk,
   input logic             rst_n,
   register_file_if.slave  bus
);

   state_t                          state, state_nxt;
   logic   [ADDR_W-1:0]             ptr, ptr_nxt;
   logic                            clr_done_q, clr_done_nxt;
   logic                            busy;
   logic   [NUM_REGS-1:0]           clr_vec;
   logic   [NUM_REGS-1:0]           we;
   logic                            wr_ok;
   logic   [NUM_REGS-1:0][DATA_W-1:0] mem;
   logic   [DATA_W-1:0]             rd_a, rd_b;
   logic                            idx0_unused;

   // rst_n gates acceptance so nothing is forwarded while held in reset
   assign wr_ok = bus.wr_en & ~busy & (bus.wr_addr != '0) & rst_n;

   wr_decoder u_wr_decoder (
      .en     (wr_ok),
      .addr   (bus.wr_addr),
      .onehot (we)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ptr        <= '0;
         clr_done_q <= 1'b0;
      end else begin
         state      <= state_nxt;
         ptr        <= ptr_nxt;
         clr_done_q <= clr_done_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      ptr_nxt      = ptr;
      clr_done_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (bus.clr_req) begin
               state_nxt = SWEEP;
               ptr_nxt   = ADDR_W'(1);
            end
         end
         SWEEP: begin
            if (ptr == ADDR_W'(NUM_REGS - 1)) begin
               state_nxt    = IDLE;
               ptr_nxt      = '0;
               clr_done_nxt = 1'b1;
            end else begin
               ptr_nxt = ptr + ADDR_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            ptr_nxt   = '0;
         end
      endcase
   end

   always_comb begin
      busy    = (state == SWEEP);
      clr_vec = '0;
      if (state == SWEEP) begin
         clr_vec = {{(NUM_REGS-1){1'b0}}, 1'b1} << ptr;
      end
   end

   // Writes and sweep clears never coincide (writes need busy low), but the
   // clear is given priority anyway so a sweep always wins.
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
      if (i == 0) begin : g_zero
         assign mem[i] = '0;
      end else begin : g_reg
         logic [DATA_W-1:0] q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               q <= '0;
            end else if (clr_vec[i]) begin
               q <= '0;
            end else if (we[i]) begin
               q <= bus.wr_data;
            end
         end
         assign mem[i] = q;
      end
   end

   assign idx0_unused = we[0] | clr_vec[0];

   always_comb begin
      rd_a = mem[bus.rd_addr_a];
      rd_b = mem[bus.rd_addr_b];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (bus.wr_addr == bus.rd_addr_a)) begin
         rd_a = bus.wr_data;
      end
      if (wr_ok && (bus.wr_addr == bus.rd_addr_b)) begin
         rd_b = bus.wr_data;
      end
`else
      rd_a = rd_a;
      rd_b = rd_b;
`endif
   end

   assign bus.rd_data_a = rd_a;
   assign bus.rd_data_b = rd_b;
   assign bus.busy      = busy;
   assign bus.clr_done  = clr_done_q;
   assign bus.wr_drop   = bus.wr_en & busy;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: table-driven read/write vectors
// followed by hand-written sweep, drop, bypass and reset-abort sequences.
module tb_register_file;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   register_file_if #(.DATA_W(32)) bus ();

   register_file #(.DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr_en;
      logic [4:0]  wr_addr;
      logic [31:0] wr_data;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [31:0] ea;
      logic [31:0] eb;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.wr_en     = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      bus.clr_req   = 1'b0;
   endtask

   task automatic write(input logic [4:0] a, input logic [31:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      tick();
      bus.wr_en   = 1'b0;
   endtask

   initial begin
      int busy_cnt, done_cnt, rises;
      bit prev_busy, seen;
      logic [31:0] exp_v;

      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      idle_inputs();
      bus.rd_addr_a = '0;
      bus.rd_addr_b = '0;

      tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd4,  5'd0,  32'h0,        32'h0};
      tbl[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
      tbl[2] = '{1'b1, 5'd0,  32'h1234,     5'd5,  5'd1,  32'hDEADBEEF, 32'h0};
      tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
      tbl[4] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd5,  5'd1,  32'hDEADBEEF, 32'h0};
      tbl[5] = '{1'b1, 5'd1,  32'h11111111, 5'd31, 5'd5,  32'hA5A5A5A5, 32'hDEADBEEF};
      tbl[6] = '{1'b1, 5'd5,  32'hCAFEF00D, 5'd1,  5'd1,  32'h11111111, 32'h11111111};
      tbl[7] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'hCAFEF00D, 32'hA5A5A5A5};
      tbl[8] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0};

      // In reset: outputs quiet even with a write aimed at the read address
      bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'hFFFFFFFF;
      bus.rd_addr_a = 5'd3; bus.rd_addr_b = 5'd3;
      #12;
      chk("rst_rd_a", bus.rd_data_a, 32'h0);
      chk("rst_rd_b", bus.rd_data_b, 32'h0);
      chk("rst_drop", {31'b0, bus.wr_drop}, 32'h0);
      chk("rst_busy", {31'b0, bus.busy}, 32'h0);
      chk("rst_done", {31'b0, bus.clr_done}, 32'h0);
      idle_inputs();
      #5 rst_n = 1'b1;
      tick();
      chk("rst_r3_unwritten", bus.rd_data_a, 32'h0);

      for (int i = 0; i < 9; i++) begin
         bus.wr_en     = tbl[i].wr_en;
         bus.wr_addr   = tbl[i].wr_addr;
         bus.wr_data   = tbl[i].wr_data;
         bus.rd_addr_a = tbl[i].ra;
         bus.rd_addr_b = tbl[i].rb;
         #1;
         chk($sformatf("vec%0d_a", i), bus.rd_data_a, tbl[i].ea);
         chk($sformatf("vec%0d_b", i), bus.rd_data_b, tbl[i].eb);
         chk($sformatf("vec%0d_drop", i), {31'b0, bus.wr_drop}, 32'h0);
         tick();
      end
      idle_inputs();

      // Fill r1..r31 with their index, then sweep
      for (int i = 1; i < 32; i++) write(5'(i), 32'(i));
      bus.rd_addr_a = 5'd17; bus.rd_addr_b = 5'd31;
      #1;
      chk("fill_r17", bus.rd_data_a, 32'd17);
      chk("fill_r31", bus.rd_data_b, 32'd31);

      bus.clr_req = 1'b1;
      #1;
      chk("clr_busy_not_yet", {31'b0, bus.busy}, 32'h0);
      tick();
      bus.clr_req = 1'b0;
      busy_cnt = 0; done_cnt = 0; rises = 0; prev_busy = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (bus.busy) busy_cnt++;
         if (bus.busy && !prev_busy) rises++;
         if (bus.clr_done) begin
            done_cnt++;
            chk("done_after_busy", {30'b0, prev_busy, bus.busy}, 32'h2);
         end
         if (bus.busy && busy_cnt == 10) begin
            bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h55;
            bus.rd_addr_a = 5'd7; bus.rd_addr_b = 5'd20;
            #1;
            chk("sweep10_drop", {31'b0, bus.wr_drop}, 32'h1);
            chk("sweep10_r7_cleared", bus.rd_data_a, 32'h0);
            chk("sweep10_r20_old", bus.rd_data_b, 32'd20);
         end
         if (bus.busy && busy_cnt == 12) bus.clr_req = 1'b1;
         prev_busy = bus.busy;
         tick();
         idle_inputs();
      end
      chk("sweep_busy_cycles", 32'(busy_cnt), 32'd31);
      chk("sweep_busy_runs", 32'(rises), 32'd1);
      chk("sweep_done_cycles", 32'(done_cnt), 32'd1);
      for (int i = 0; i < 32; i++) begin
         bus.rd_addr_a = 5'(i); bus.rd_addr_b = 5'(31 - i);
         #1;
         chk($sformatf("post_sweep_a%0d", i), bus.rd_data_a, 32'h0);
         chk($sformatf("post_sweep_b%0d", 31 - i), bus.rd_data_b, 32'h0);
      end

      // Write and clear request together: write lands, then sweep clears it
      bus.wr_en = 1'b1; bus.wr_addr = 5'd12; bus.wr_data = 32'h77; bus.clr_req = 1'b1;
      bus.rd_addr_a = 5'd12;
      tick();
      idle_inputs();
      chk("wrclr_busy", {31'b0, bus.busy}, 32'h1);
      chk("wrclr_written", bus.rd_data_a, 32'h77);
      seen = 1'b0;
      for (int n = 0; n < 40 && !seen; n++) begin
         tick();
         if (bus.clr_done) seen = 1'b1;
      end
      chk("wrclr_done_seen", {31'b0, seen}, 32'h1);
      chk("wrclr_cleared", bus.rd_data_a, 32'h0);

      // Same-cycle read of the entry being written
      write(5'd3, 32'h11);
      bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'hAA;
      bus.rd_addr_a = 5'd3;
      #1;
      exp_v = BYP ? 32'hAA : 32'h11;
      chk("same_cycle_r3", bus.rd_data_a, exp_v);
      tick();
      idle_inputs();
      chk("next_cycle_r3", bus.rd_data_a, 32'hAA);

      // Reset in the middle of a sweep
      write(5'd30, 32'h30);
      bus.clr_req = 1'b1;
      tick();
      bus.clr_req = 1'b0;
      busy_cnt = 1;
      for (int n = 0; n < 40 && busy_cnt < 15; n++) begin
         tick();
         if (bus.busy) busy_cnt++;
      end
      chk("abort_reached_15", {31'b0, bus.busy}, 32'h1);
      bus.rd_addr_a = 5'd30; bus.rd_addr_b = 5'd3;
      #1;
      chk("abort_r30_before", bus.rd_data_a, 32'h30);
      bus.wr_en = 1'b1; bus.wr_addr = 5'd4; bus.wr_data = 32'h4;
      #1 rst_n = 1'b0;
      #1;
      chk("abort_busy", {31'b0, bus.busy}, 32'h0);
      chk("abort_drop", {31'b0, bus.wr_drop}, 32'h0);
      chk("abort_r30", bus.rd_data_a, 32'h0);
      chk("abort_r3", bus.rd_data_b, 32'h0);
      idle_inputs();
      tick();
      #2 rst_n = 1'b1;
      #2;
      chk("abort_done_low", {31'b0, bus.clr_done}, 32'h0);
      write(5'd9, 32'h9);
      bus.rd_addr_a = 5'd9; bus.rd_addr_b = 5'd4;
      #1;
      chk("abort_r9_written", bus.rd_data_a, 32'h9);
      chk("abort_r4_not_written", bus.rd_data_b, 32'h0);
      chk("abort_idle", {31'b0, bus.busy}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
